// File: rtl/pheap_level_pkg.sv
// Shared types, constants and helpers for the pipelined-heap level managers.
// Key/value widths are fixed here; a level's capacity must fit in CAP_W bits.
package pheap_level_pkg;

    localparam int KEY_W      = 8;
    localparam int VAL_W      = 8;
    localparam int MAX_LEVELS = 8;
    localparam int CAP_W      = MAX_LEVELS;

    typedef enum logic [1:0] {
        LENQ  = 2'd0,
        LDEQ  = 2'd1,
        LREPL = 2'd2
    } opcode_t;

    typedef enum logic [1:0] {
        DONE       = 2'd0,
        WAIT       = 2'd1,
        NEXT_LEVEL = 2'd2
    } done_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;

    typedef struct packed {
        logic             active;
        kv_t              kv;
        logic [CAP_W-1:0] capacity;
    } entry_t;

    localparam logic [KEY_W-1:0] KEY0        = '0;
    localparam kv_t              KV_EMPTY    = '0;
    localparam entry_t           ENTRY_EMPTY = '0;

    // Free slots in the subtree rooted at one node of the given level.
    function automatic logic [CAP_W-1:0] cap_init(input int levels, input int level);
        int span;
        span = levels - level + 1;
        return CAP_W'((32'd1 << span) - 32'd1);
    endfunction

    // Key that loses every comparison, so an emptied node never wins.
    function automatic kv_t fill_kv(input bit min_mode);
        kv_t f;
        f     = KV_EMPTY;
        f.key = min_mode ? {KEY_W{1'b1}} : KEY0;
        return f;
    endfunction

    function automatic logic better(input entry_t a, input entry_t b, input bit min_mode);
        if (!a.active) return 1'b0;
        if (!b.active) return 1'b1;
        return min_mode ? (a.kv.key < b.kv.key) : (a.kv.key > b.kv.key);
    endfunction

endpackage

// File: rtl/pheap_child_sel.sv
// Combinational child picker: chooses which child an operation continues into
// and which child kv would be promoted into the current node.
module pheap_child_sel
    import pheap_level_pkg::*;
#(
    parameter bit MIN_MODE = 1'b0
) (
    input  entry_t  i_child_l,
    input  entry_t  i_child_r,
    input  kv_t     i_in,
    input  opcode_t i_op,
    output logic    o_end_pos,
    output kv_t     o_win_kv,
    output logic    o_in_stays
);

    entry_t w_in_e;
    logic   w_right_best;

    // NOTE: every output is given a value before any branch, so no latch is inferred.
    always_comb begin
        w_in_e        = ENTRY_EMPTY;
        w_in_e.active = 1'b1;
        w_in_e.kv     = i_in;

        // Left wins ties: right is chosen only when strictly better.
        w_right_best = better(i_child_r, i_child_l, MIN_MODE);
        o_win_kv     = w_right_best ? i_child_r.kv : i_child_l.kv;
        o_in_stays   = !better(i_child_l, w_in_e, MIN_MODE) &&
                       !better(i_child_r, w_in_e, MIN_MODE);
        o_end_pos    = w_right_best;

        if (i_op == LENQ) begin
            if (!i_child_r.active) begin
                o_end_pos = 1'b1;
            end else if (!i_child_l.active) begin
                o_end_pos = 1'b0;
            end else if ((i_child_l.capacity != '0) && (i_child_r.capacity != '0)) begin
                o_end_pos = better(i_child_l, i_child_r, MIN_MODE);
            end else if (i_child_l.capacity != '0) begin
                o_end_pos = 1'b0;
            end else begin
                o_end_pos = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pheap_level.sv
// One level of the pipelined-heap priority queue: owns 2^(LEVEL-1) nodes, runs a
// single ENQ/DEQ/REPL step on the selected node and hands the residue downward.
module pheap_level
    import pheap_level_pkg::*;
#(
    parameter int LEVELS   = 4,
    parameter int LEVEL    = 1,
    parameter bit MIN_MODE = 1'b0,
    parameter int PW       = (LEVEL > 1) ? LEVEL - 1 : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  opcode_t          op,
    input  logic [PW-1:0]    pos_in,
    input  kv_t              in,
    input  entry_t           rBotL,
    input  entry_t           rBotR,
    output logic             active,
    output done_t            done,
    output logic [PW-1:0]    raddrBot,
    output logic [LEVEL-1:0] pos_out,
    output kv_t              out,
    output kv_t              node_out,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int               NODES    = 1 << (LEVEL - 1);
    localparam logic [CAP_W-1:0] CAP_INIT = cap_init(LEVELS, LEVEL);
    localparam bit               IS_LEAF  = (LEVEL == LEVELS);
    localparam kv_t              FILL     = fill_kv(MIN_MODE);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t           r_state;
    state_t           w_state_next;
    opcode_t          r_op;
    logic [PW-1:0]    r_pos;
    kv_t              r_in;
    entry_t           r_nodes [NODES];
    logic             r_active;
    done_t            r_done;
    kv_t              r_out;
    logic [LEVEL-1:0] r_pos_out;
    logic             r_err;

    logic [PW-1:0]    w_idx;
    logic [PW-1:0]    w_view_idx;
    entry_t           w_node;
    entry_t           w_view;
    entry_t           w_in_e;
    entry_t           w_child_l;
    entry_t           w_child_r;
    logic             w_end_pos;
    kv_t              w_win_kv;
    logic             w_in_stays;
    logic [LEVEL-1:0] w_pos_next;
    logic             w_wr;
    entry_t           w_wr_entry;
    kv_t              w_out;
    done_t            w_done;
    logic             w_err;

    // The top level has a single node, so its index inputs are don't-care.
    assign w_idx      = (LEVEL == 1) ? '0 : r_pos;
    assign w_view_idx = (LEVEL == 1) ? '0 : pos_in;
    assign w_node     = r_nodes[w_idx];
    assign w_view     = r_nodes[w_view_idx];

    always_comb begin
        w_child_l        = rBotL;
        w_child_r        = rBotR;
        w_child_l.active = rBotL.active & ~IS_LEAF;
        w_child_r.active = rBotR.active & ~IS_LEAF;
        w_in_e           = ENTRY_EMPTY;
        w_in_e.active    = 1'b1;
        w_in_e.kv        = r_in;
    end

    pheap_child_sel #(
        .MIN_MODE (MIN_MODE)
    ) u_child_sel (
        .i_child_l  (w_child_l),
        .i_child_r  (w_child_r),
        .i_in       (r_in),
        .i_op       (r_op),
        .o_end_pos  (w_end_pos),
        .o_win_kv   (w_win_kv),
        .o_in_stays (w_in_stays)
    );

    generate
        if (LEVEL == 1) begin : g_root_pos
            assign w_pos_next = w_end_pos;
        end else begin : g_inner_pos
            assign w_pos_next = {r_pos, w_end_pos};
        end
    endgenerate

    // Result of the EXEC cycle for the latched node.
    always_comb begin
        w_wr       = 1'b0;
        w_wr_entry = w_node;
        w_out      = KV_EMPTY;
        w_done     = DONE;
        w_err      = 1'b0;
        case (r_op)
            LENQ: begin
                if (w_node.capacity == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_wr                = 1'b1;
                    w_wr_entry.capacity = w_node.capacity - 1'b1;
                    if (!w_node.active) begin
                        w_wr_entry.active = 1'b1;
                        w_wr_entry.kv     = r_in;
                    end else begin
                        if (better(w_in_e, w_node, MIN_MODE)) begin
                            w_wr_entry.kv = r_in;
                            w_out         = w_node.kv;
                        end else begin
                            w_out = r_in;
                        end
                        w_done = IS_LEAF ? DONE : NEXT_LEVEL;
                    end
                end
            end
            LDEQ: begin
                if (!w_node.active) begin
                    w_err = 1'b1;
                end else begin
                    w_wr                = 1'b1;
                    w_out               = w_node.kv;
                    w_wr_entry.capacity = (w_node.capacity >= CAP_INIT) ? CAP_INIT
                                                                         : w_node.capacity + 1'b1;
                    if (!w_child_l.active && !w_child_r.active) begin
                        w_wr_entry.active = 1'b0;
                        w_wr_entry.kv     = FILL;
                    end else begin
                        w_wr_entry.kv = w_win_kv;
                        w_done        = NEXT_LEVEL;
                    end
                end
            end
            LREPL: begin
                if (!w_node.active) begin
                    w_err = 1'b1;
                end else begin
                    w_wr = 1'b1;
                    if (w_in_stays) begin
                        w_wr_entry.kv = r_in;
                    end else begin
                        w_wr_entry.kv = w_win_kv;
                        w_out         = r_in;
                        w_done        = NEXT_LEVEL;
                    end
                end
            end
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= LENQ;
            r_pos     <= '0;
            r_in      <= KV_EMPTY;
            r_active  <= 1'b0;
            r_done    <= DONE;
            r_out     <= KV_EMPTY;
            r_pos_out <= '0;
            r_err     <= 1'b0;
            // NOTE: the node store is reset because every node must start empty with full capacity.
            for (int i = 0; i < NODES; i++) begin
                r_nodes[i] <= '{active: 1'b0, kv: FILL, capacity: CAP_INIT};
            end
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_pos    <= pos_in;
                        r_in     <= in;
                        r_active <= 1'b1;
                        r_done   <= WAIT;
                    end else begin
                        r_done <= DONE;
                    end
                end
                S_EXEC: begin
                    r_active  <= 1'b0;
                    r_done    <= w_done;
                    r_out     <= w_out;
                    r_pos_out <= w_pos_next;
                    r_err     <= w_err;
                    if (w_wr) r_nodes[w_idx] <= w_wr_entry;
                end
                default: r_active <= 1'b0;
            endcase
        end
    end

    assign active   = r_active;
    assign done     = r_done;
    assign raddrBot = r_pos;
    assign pos_out  = r_pos_out;
    assign out      = r_out;
    assign err      = r_err;
    assign node_out = w_view.kv;
    assign full     = (w_view.capacity == '0);
    assign empty    = (w_view.capacity == CAP_INIT);

endmodule

// File: tb/tb_pheap_level.sv
// Scoreboard bench for pheap_level: a max-mode root, a min-mode root and a leaf
// level (LEVELS=3), with expected results queued at stimulus and popped at completion.
module tb_pheap_level;
    import pheap_level_pkg::*;

    typedef struct {
        int               lat;
        done_t            done;
        kv_t              out;
        logic [3:0]       pos;
        logic             err;
        kv_t              node;
        logic [CAP_W-1:0] cap;
        bit               chk_pos;
    } res_t;

    logic    clk = 1'b0;
    logic    rst_n;
    opcode_t op;
    kv_t     in_kv;
    entry_t  bot_l, bot_r;
    logic    start_a, start_b, start_c;
    logic [1:0] pos_c;
    logic    pos_ab;

    logic a_active, b_active, c_active;
    done_t a_done, b_done, c_done;
    logic a_raddr, b_raddr;
    logic [1:0] c_raddr;
    logic a_pos_out, b_pos_out;
    logic [2:0] c_pos_out;
    kv_t a_out, b_out, c_out, a_node, b_node, c_node;
    logic a_full, b_full, c_full, a_empty, b_empty, c_empty, a_err, b_err, c_err;

    int checks = 0;
    int errors = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    pheap_level #(.LEVELS(3), .LEVEL(1), .MIN_MODE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op(op), .pos_in(pos_ab), .in(in_kv),
        .rBotL(bot_l), .rBotR(bot_r), .active(a_active), .done(a_done), .raddrBot(a_raddr),
        .pos_out(a_pos_out), .out(a_out), .node_out(a_node), .full(a_full), .empty(a_empty),
        .err(a_err));

    pheap_level #(.LEVELS(3), .LEVEL(1), .MIN_MODE(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op(op), .pos_in(pos_ab), .in(in_kv),
        .rBotL(bot_l), .rBotR(bot_r), .active(b_active), .done(b_done), .raddrBot(b_raddr),
        .pos_out(b_pos_out), .out(b_out), .node_out(b_node), .full(b_full), .empty(b_empty),
        .err(b_err));

    pheap_level #(.LEVELS(3), .LEVEL(3), .MIN_MODE(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op(op), .pos_in(pos_c), .in(in_kv),
        .rBotL(bot_l), .rBotR(bot_r), .active(c_active), .done(c_done), .raddrBot(c_raddr),
        .pos_out(c_pos_out), .out(c_out), .node_out(c_node), .full(c_full), .empty(c_empty),
        .err(c_err));

    function automatic kv_t mk(input logic [KEY_W-1:0] k);
        kv_t r;
        r.key   = k;
        r.value = k ^ 8'h5A;
        return r;
    endfunction

    function automatic entry_t ent(input logic act, input kv_t kv, input int cap);
        entry_t e;
        e.active   = act;
        e.kv       = kv;
        e.capacity = CAP_W'(cap);
        return e;
    endfunction

    function automatic res_t ex(input done_t d, input kv_t o, input int p, input logic e,
                                input kv_t n, input int cap, input bit cp);
        res_t r;
        r.lat = 2; r.done = d; r.out = o; r.pos = 4'(p); r.err = e;
        r.node = n; r.cap = CAP_W'(cap); r.chk_pos = cp;
        return r;
    endfunction

    function automatic logic dut_active(input int d);
        case (d)
            0:       return a_active;
            1:       return b_active;
            default: return c_active;
        endcase
    endfunction

    function automatic res_t sample(input int d);
        res_t r;
        r.lat = 0; r.chk_pos = 1'b0;
        case (d)
            0: begin
                r.done = a_done; r.out = a_out; r.pos = {3'b0, a_pos_out}; r.err = a_err;
                r.node = a_node; r.cap = dut_a.r_nodes[0].capacity;
            end
            1: begin
                r.done = b_done; r.out = b_out; r.pos = {3'b0, b_pos_out}; r.err = b_err;
                r.node = b_node; r.cap = dut_b.r_nodes[0].capacity;
            end
            default: begin
                r.done = c_done; r.out = c_out; r.pos = {1'b0, c_pos_out}; r.err = c_err;
                r.node = c_node; r.cap = dut_c.r_nodes[pos_c].capacity;
            end
        endcase
        return r;
    endfunction

    // Drive one operation, wait (bounded) for it to finish, pop and score the expectation.
    task automatic run_op(input string nm, input int d, input opcode_t o,
                          input logic [KEY_W-1:0] k, input res_t e);
        res_t got, exp_r;
        int   cyc;
        sb.push_back(e);
        @(negedge clk);
        op = o; in_kv = mk(k);
        case (d) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        cyc = 1;
        while (dut_active(d) && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        got   = sample(d);
        exp_r = sb.pop_front();
        checks += 6;
        if (cyc !== exp_r.lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, exp_r.lat);
        end
        if (got.done !== exp_r.done) begin
            errors++; $display("FAIL %s done: got %0d expected %0d", nm, got.done, exp_r.done);
        end
        if (got.err !== exp_r.err) begin
            errors++; $display("FAIL %s err: got %b expected %b", nm, got.err, exp_r.err);
        end
        if (got.out !== exp_r.out) begin
            errors++; $display("FAIL %s out: got %h expected %h", nm, got.out, exp_r.out);
        end
        if (got.node !== exp_r.node) begin
            errors++; $display("FAIL %s node: got %h expected %h", nm, got.node, exp_r.node);
        end
        if (got.cap !== exp_r.cap) begin
            errors++; $display("FAIL %s capacity: got %0d expected %0d", nm, got.cap, exp_r.cap);
        end
        if (exp_r.chk_pos) begin
            checks++;
            if (got.pos !== exp_r.pos) begin
                errors++; $display("FAIL %s pos_out: got %0d expected %0d", nm, got.pos, exp_r.pos);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (a_active !== 1'b0 || a_done !== DONE || a_err !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: active=%b done=%0d err=%b expected 0/0/0", a_active, a_done, a_err);
        end
        if (a_out !== KV_EMPTY || a_pos_out !== 1'b0) begin
            errors++; $display("FAIL reset_out: out=%h pos=%b expected 0/0", a_out, a_pos_out);
        end
        if (a_empty !== 1'b1 || a_full !== 1'b0) begin
            errors++; $display("FAIL reset_a_cap: empty=%b full=%b expected 1/0", a_empty, a_full);
        end
        if (a_node !== KV_EMPTY) begin
            errors++; $display("FAIL reset_a_fill: got %h expected %h", a_node, KV_EMPTY);
        end
        if (b_node.key !== 8'hFF) begin
            errors++; $display("FAIL reset_b_fill: got %h expected ff", b_node.key);
        end
        if (dut_a.r_nodes[0].capacity !== CAP_W'(7)) begin
            errors++; $display("FAIL reset_a_capval: got %0d expected 7", dut_a.r_nodes[0].capacity);
        end
        if (dut_c.r_nodes[2].capacity !== CAP_W'(1) || c_empty !== 1'b1) begin
            errors++; $display("FAIL reset_c_cap: got %0d expected 1", dut_c.r_nodes[2].capacity);
        end
        if (dut_a.r_nodes[0].active !== 1'b0) begin
            errors++; $display("FAIL reset_a_active: got %b expected 0", dut_a.r_nodes[0].active);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_enq();
        bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY;
        run_op("enq_first", 0, LENQ, 8'd5, ex(DONE, KV_EMPTY, 0, 1'b0, mk(5), 6, 1'b0));
        run_op("enq_swap",  0, LENQ, 8'd9, ex(NEXT_LEVEL, mk(5), 1, 1'b0, mk(9), 5, 1'b1));
    endtask

    task automatic test_deq();
        bot_l = ent(1'b1, mk(7), 3); bot_r = ent(1'b1, mk(3), 3);
        run_op("deq_max", 0, LDEQ, 8'd0, ex(NEXT_LEVEL, mk(9), 0, 1'b0, mk(7), 6, 1'b1));
    endtask

    task automatic test_enq_route();
        bot_l = ent(1'b1, mk(7), 3); bot_r = ent(1'b1, mk(3), 3);
        run_op("enq_rule3", 0, LENQ, 8'd2, ex(NEXT_LEVEL, mk(2), 1, 1'b0, mk(7), 5, 1'b1));
        bot_r = ent(1'b1, mk(3), 0);
        run_op("enq_rule4", 0, LENQ, 8'd8, ex(NEXT_LEVEL, mk(7), 0, 1'b0, mk(8), 4, 1'b1));
        bot_l = ent(1'b1, mk(7), 0);
        run_op("enq_rule5", 0, LENQ, 8'd1, ex(NEXT_LEVEL, mk(1), 1, 1'b0, mk(8), 3, 1'b1));
        bot_l = ent(1'b0, mk(7), 3);
        run_op("enq_rule2", 0, LENQ, 8'd6, ex(NEXT_LEVEL, mk(6), 0, 1'b0, mk(8), 2, 1'b1));
    endtask

    task automatic test_repl();
        kv_t tie_kv;
        bot_l = ent(1'b1, mk(7), 3); bot_r = ent(1'b1, mk(3), 3);
        run_op("repl_stay", 0, LREPL, 8'd9, ex(DONE, KV_EMPTY, 0, 1'b0, mk(9), 2, 1'b0));
        tie_kv = mk(7); tie_kv.value = 8'h11;
        bot_r = ent(1'b1, tie_kv, 3);
        run_op("repl_tie", 0, LREPL, 8'd4, ex(NEXT_LEVEL, mk(4), 0, 1'b0, mk(7), 2, 1'b1));
        bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY;
        run_op("deq_last", 0, LDEQ, 8'd0, ex(DONE, mk(7), 0, 1'b0, KV_EMPTY, 3, 1'b0));
    endtask

    task automatic test_min_mode();
        kv_t min_fill;
        min_fill = KV_EMPTY; min_fill.key = 8'hFF;
        bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY;
        run_op("min_enq", 1, LENQ, 8'd2, ex(DONE, KV_EMPTY, 0, 1'b0, mk(2), 6, 1'b0));
        bot_l = ent(1'b1, mk(7), 3); bot_r = ent(1'b1, mk(3), 3);
        run_op("min_deq", 1, LDEQ, 8'd0, ex(NEXT_LEVEL, mk(2), 1, 1'b0, mk(3), 7, 1'b1));
        bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY;
        run_op("min_deq_sat", 1, LDEQ, 8'd0, ex(DONE, mk(3), 0, 1'b0, min_fill, 7, 1'b0));
    endtask

    task automatic test_leaf();
        pos_c = 2'd2;
        bot_l = ent(1'b1, mk(9), 1); bot_r = ent(1'b1, mk(8), 1);
        run_op("leaf_enq", 2, LENQ, 8'd6, ex(DONE, KV_EMPTY, 0, 1'b0, mk(6), 0, 1'b0));
        checks += 2;
        if (c_full !== 1'b1) begin
            errors++; $display("FAIL leaf_full: got %b expected 1", c_full);
        end
        if (c_raddr !== 2'd2) begin
            errors++; $display("FAIL leaf_raddr: got %0d expected 2", c_raddr);
        end
        run_op("leaf_enq_full", 2, LENQ, 8'd4, ex(DONE, KV_EMPTY, 0, 1'b1, mk(6), 0, 1'b0));
        run_op("leaf_repl", 2, LREPL, 8'd4, ex(DONE, KV_EMPTY, 0, 1'b0, mk(4), 0, 1'b0));
        run_op("leaf_deq", 2, LDEQ, 8'd0, ex(DONE, mk(4), 0, 1'b0, KV_EMPTY, 1, 1'b0));
    endtask

    task automatic test_reset_abort();
        bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY;
        @(negedge clk);
        op = LENQ; in_kv = mk(8'd5); start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        checks += 3;
        if (dut_a.r_nodes[0].active !== 1'b0 || dut_a.r_nodes[0].capacity !== CAP_W'(7)) begin
            errors++; $display("FAIL abort_node: active=%b cap=%0d expected 0/7",
                               dut_a.r_nodes[0].active, dut_a.r_nodes[0].capacity);
        end
        if (a_active !== 1'b0 || a_done !== DONE) begin
            errors++; $display("FAIL abort_ctrl: active=%b done=%0d expected 0/0", a_active, a_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (a_empty !== 1'b1) begin
            errors++; $display("FAIL abort_empty: got %b expected 1", a_empty);
        end
        run_op("deq_empty", 0, LDEQ, 8'd0, ex(DONE, KV_EMPTY, 0, 1'b1, KV_EMPTY, 7, 1'b0));
        @(negedge clk);
        checks++;
        if (a_err !== 1'b0) begin
            errors++; $display("FAIL err_pulse: got %b expected 0", a_err);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op = LENQ; in_kv = mk(8'd5); start_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        checks += 2;
        if (dut_a.r_nodes[0].capacity !== CAP_W'(6) || a_node !== mk(5)) begin
            errors++; $display("FAIL b2b_single: cap=%0d node=%h expected 6/%h",
                               dut_a.r_nodes[0].capacity, a_node, mk(5));
        end
        if (a_active !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: active=%b expected 0", a_active);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        op = LENQ; in_kv = KV_EMPTY; bot_l = ENTRY_EMPTY; bot_r = ENTRY_EMPTY;
        pos_c = 2'd2; pos_ab = 1'b0;
        test_reset();
        test_enq();
        test_deq();
        test_enq_route();
        test_repl();
        test_min_mode();
        test_leaf();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
